// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: multiply/divide op codes, FSM encoding and default width.
package cpu_pkg;

  localparam int unsigned MD_WIDTH = 16;

  localparam logic [1:0] MD_MUL   = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_REM   = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock,
// with a start/busy/done handshake and a single shared adder/subtractor.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_signed,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_r
);

  localparam int unsigned CntW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [1:0]       op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bzero_q, bzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div;
  logic [WIDTH:0]   add_x, add_y;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Sign handling is only meaningful for DIV/REM; MUL paths latch the raw operands.
  assign a_neg = i_signed & i_a[WIDTH-1];
  assign b_neg = i_signed & i_b[WIDTH-1];
  assign a_mag = a_neg ? (WIDTH'(0) - i_a) : i_a;
  assign b_mag = b_neg ? (WIDTH'(0) - i_b) : i_b;

  assign is_div = op_q[1];

  // Shared adder: accumulate multiplicand for MUL, trial-subtract divisor for DIV.
  // For DIV the carry out (sum[WIDTH+1]) is set exactly when no borrow occurs.
  assign add_x = is_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
  assign add_y = is_div ? ~{1'b0, m_q} : {1'b0, m_q};
  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, is_div};

  assign quo_fix = neg_quo_q ? (WIDTH'(0) - lo_q) : lo_q;
  assign rem_fix = neg_rem_q ? (WIDTH'(0) - hi_q) : hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    r_d       = r_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d   = StRun;
          busy_d    = 1'b1;
          cnt_d     = CntW'(WIDTH - 1);
          op_d      = i_op;
          hi_d      = '0;
          bzero_d   = (i_b == '0);
          neg_quo_d = (a_neg ^ b_neg) & (i_b != '0);
          neg_rem_d = a_neg;
          if (i_op[1]) begin
            lo_d = a_mag;
            m_d  = b_mag;
          end else begin
            lo_d = i_b;
            m_d  = i_a;
          end
        end
      end

      StRun: begin
        if (is_div) begin
          hi_d = sum[WIDTH+1] ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], sum[WIDTH+1]};
        end else if (lo_q[0]) begin
          hi_d = sum[WIDTH:1];
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        unique case (op_q)
          MD_MUL:   r_d = lo_q;
          MD_MULHU: r_d = hi_q;
          MD_DIV:   r_d = bzero_q ? '1 : quo_fix;
          MD_REM:   r_d = rem_fix;
          default:  r_d = r_q;
        endcase
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      r_q       <= r_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_r    = r_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results popped on each o_done.
module tb_muldiv_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         sgn;
  logic         busy, done;
  logic [W-1:0] r;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_op    (op),
    .i_signed(sgn),
    .o_busy  (busy),
    .o_done  (done),
    .o_r     (r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Independent reference built on the simulator's own arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [1:0] mop, input logic ms);
    logic [31:0] prod;
    int          sa, sb, res;
    prod = {16'b0, ma} * {16'b0, mb};
    sa = ms ? int'($signed(ma)) : int'(ma);
    sb = ms ? int'($signed(mb)) : int'(mb);
    case (mop)
      2'b00:   res = int'(prod[15:0]);
      2'b01:   res = int'(prod[31:16]);
      2'b10:   res = (mb == 0) ? 32'hFFFF : sa / sb;
      default: res = (mb == 0) ? int'(ma) : sa % sb;
    endcase
    return res[W-1:0];
  endfunction

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check_eq("spurious_done", {31'b0, done}, 32'd0);
      else check_eq("result", r, exp_q.pop_front());
    end
  end

  // Issue one op, expect done 17 edges after acceptance and busy high for 17 cycles.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                       input logic ts, input logic [W-1:0] want, input bit glitch);
    int lat;
    int bcnt;
    @(negedge clk);
    a = ta; b = tb; op = top; sgn = ts; start = 1'b1;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (glitch && lat == 5) begin
        a = ~ta; b = tb + 16'd3; op = ~top; sgn = ~ts; start = 1'b1;
      end
      if (glitch && lat == 6) start = 1'b0;
      if (done) break;
      if (busy) bcnt++;
    end
    check_eq("latency", lat, 17);
    check_eq("busy_cycles", bcnt, 17);
  endtask

  initial begin
    int d1;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0; sgn = 1'b0;
    #12;
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_done", {31'b0, done}, 0);
    check_eq("rst_r", r, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h1234, 16'h0010, 2'b00, 1'b0, 16'h2340, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 2'b01, 1'b0, 16'hFFFE, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 16'h0001, 1'b0);
    do_op(16'hFFF9, 16'h0002, 2'b10, 1'b1, 16'hFFFD, 1'b0);
    do_op(16'hFFF9, 16'h0002, 2'b11, 1'b1, 16'hFFFF, 1'b0);
    do_op(16'd100, 16'd7, 2'b10, 1'b0, 16'h000E, 1'b0);
    do_op(16'd100, 16'd7, 2'b11, 1'b0, 16'h0002, 1'b0);
    do_op(16'h1234, 16'h0000, 2'b10, 1'b0, 16'hFFFF, 1'b0);
    do_op(16'h1234, 16'h0000, 2'b11, 1'b0, 16'h1234, 1'b0);
    do_op(16'hFF00, 16'h0000, 2'b10, 1'b1, 16'hFFFF, 1'b0);
    do_op(16'hFF00, 16'h0000, 2'b11, 1'b1, 16'hFF00, 1'b0);
    do_op(16'h8000, 16'hFFFF, 2'b10, 1'b1, 16'h8000, 1'b0);
    do_op(16'h8000, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 1'b0);

    // Restart attempt mid-run must be ignored.
    do_op(16'h0003, 16'h0005, 2'b00, 1'b0, 16'h000F, 1'b1);

    // Start in the done cycle: accepted, next done 18 cycles later.
    do_op(16'd1000, 16'd9, 2'b10, 1'b0, 16'd111, 1'b0);
    d1 = cyc;
    do_op(16'd1000, 16'd9, 2'b11, 1'b0, 16'd1, 1'b0);
    check_eq("b2b_gap", cyc - d1, 18);

    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = (i == 3) ? 16'h0000 : W'($urandom);
      rop = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rop, rs, model(ra, rb, rop, rs), 1'b0);
    end

    do_op(16'h0101, 16'h00FF, 2'b00, 1'b0, 16'hFFFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("r_held", r, 16'hFFFF);

    // Reset during RUN: async clear, no done afterwards.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; op = 2'b00; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", {31'b0, busy}, 0);
    check_eq("midrst_done", {31'b0, done}, 0);
    check_eq("midrst_r", r, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("post_rst_busy", {31'b0, busy}, 0);
    do_op(16'd4321, 16'd10, 2'b10, 1'b0, 16'd432, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    check_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
